// File: rtl/cache_mem_ctrl_pkg.sv
// Shared types and address-field width helpers for the direct-mapped
// write-back cache controller and its line store.
package cache_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    function automatic int offset_w();
        return 2;
    endfunction

    function automatic int word_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int words);
        return addr_w - offset_w() - word_w(words) - index_w(lines);
    endfunction

    // Burst word counter width; kept at least 1 bit so single-word lines still elaborate.
    function automatic int cnt_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Per-line valid/dirty/tag state plus the line data array; all reads are
// combinational so hits complete with zero wait states.
module cache_line_store
    import cache_mem_ctrl_pkg::*;
#(
    parameter  int LINES = 16,
    parameter  int WORDS = 4,
    parameter  int TAG_W = 24,
    localparam int IDX_W = index_w(LINES),
    localparam int WCW   = cnt_w(WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_index,
    input  logic [WCW-1:0]   i_word,
    output logic             o_valid,
    output logic             o_dirty,
    output logic [TAG_W-1:0] o_tag,
    output logic [31:0]      o_rdata,
    input  logic             i_wr_en,
    input  logic [3:0]       i_wr_be,
    input  logic [31:0]      i_wr_data,
    input  logic             i_fill_en,
    input  logic [WCW-1:0]   i_fill_word,
    input  logic [31:0]      i_fill_data,
    input  logic             i_fill_done,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  logic             i_clean,
    input  logic [WCW-1:0]   i_victim_word,
    output logic [31:0]      o_victim_data
);

    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS];
    logic [31:0]      w_merged;

    assign o_valid       = r_valid[i_index];
    assign o_dirty       = r_dirty[i_index];
    assign o_tag         = r_tag[i_index];
    assign o_rdata       = r_data[i_index][i_word];
    assign o_victim_data = r_data[i_index][i_victim_word];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[gi*8 +: 8] = i_wr_be[gi] ? i_wr_data[gi*8 +: 8] : o_rdata[gi*8 +: 8];
        end
    endgenerate

    // Only the status bits are reset; a line is never valid until a refill completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_done) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_clean) begin
            r_dirty[i_index] <= 1'b0;
        end else if (i_wr_en && (|i_wr_be)) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_data[i_index][i_fill_word] <= i_fill_data;
        end else if (i_wr_en) begin
            r_data[i_index][i_word] <= w_merged;
        end
        if (i_fill_done) begin
            r_tag[i_index] <= i_fill_tag;
        end
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller between the core
// port and a req/ack word-handshake backing memory.
module cache_mem_ctrl
    import cache_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    input  logic              wen,
    input  logic              ren,
    input  logic [3:0]        byte_sel,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int WB  = word_w(WORDS);
    localparam int IB  = index_w(LINES);
    localparam int TW  = tag_w(ADDR_W, LINES, WORDS);
    localparam int WCW = cnt_w(WORDS);
    localparam logic [WCW-1:0]   LAST_WORD = WCW'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t            r_state, w_state_next;
    logic [WCW-1:0]    r_word_cnt, w_word_cnt_next;
    logic [CNT_W-1:0]  r_hit_count, w_hit_count_next;
    logic [CNT_W-1:0]  r_miss_count, w_miss_count_next;

    logic [IB-1:0]     w_index;
    logic [TW-1:0]     w_tag;
    logic [WCW-1:0]    w_word;
    logic              w_valid, w_dirty, w_hit, w_req, w_ready;
    logic [TW-1:0]     w_line_tag;
    logic [31:0]       w_rd_word, w_victim_word;
    logic              w_wr_en, w_fill_en, w_fill_done, w_clean;
    logic [ADDR_W-1:0] w_victim_base, w_fill_base, w_word_off;
    logic              w_unused_addr_bits;

    assign w_index            = address[2+WB +: IB];
    assign w_tag              = address[ADDR_W-1 -: TW];
    assign w_unused_addr_bits = ^address[1:0];

    generate
        if (WB > 0) begin : g_word
            assign w_word = address[2 +: WB];
        end else begin : g_word_single
            assign w_word = '0;
        end
    endgenerate

    assign w_req         = wen | ren;
    assign w_hit         = w_valid && (w_line_tag == w_tag);
    assign w_victim_base = {w_line_tag, w_index, {(WB+2){1'b0}}};
    assign w_fill_base   = {w_tag, w_index, {(WB+2){1'b0}}};
    assign w_word_off    = ADDR_W'({r_word_cnt, 2'b00});

    // Reset forces the idle-looking core view even if a miss is being presented.
    assign ready      = reset | w_ready;
    assign rdata      = reset ? 32'h0 : w_rd_word;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    cache_line_store #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TW)
    ) u_store (
        .clk           (clk),
        .reset         (reset),
        .i_index       (w_index),
        .i_word        (w_word),
        .o_valid       (w_valid),
        .o_dirty       (w_dirty),
        .o_tag         (w_line_tag),
        .o_rdata       (w_rd_word),
        .i_wr_en       (w_wr_en & ~reset),
        .i_wr_be       (byte_sel),
        .i_wr_data     (wdata),
        .i_fill_en     (w_fill_en & ~reset),
        .i_fill_word   (r_word_cnt),
        .i_fill_data   (mem_rdata),
        .i_fill_done   (w_fill_done & ~reset),
        .i_fill_tag    (w_tag),
        .i_clean       (w_clean & ~reset),
        .i_victim_word (r_word_cnt),
        .o_victim_data (w_victim_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_word_cnt   <= w_word_cnt_next;
            r_hit_count  <= w_hit_count_next;
            r_miss_count <= w_miss_count_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_word_cnt_next   = r_word_cnt;
        w_hit_count_next  = r_hit_count;
        w_miss_count_next = r_miss_count;
        w_ready           = 1'b0;
        w_wr_en           = 1'b0;
        w_fill_en         = 1'b0;
        w_fill_done       = 1'b0;
        w_clean           = 1'b0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;

        case (r_state)
            IDLE: begin
                w_ready = !w_req || w_hit;
                if (w_req) begin
                    if (w_hit) begin
                        w_wr_en = wen;
                        if (r_hit_count != CNT_MAX) begin
                            w_hit_count_next = r_hit_count + 1'b1;
                        end
                    end else begin
                        // Counted on the single IDLE->miss transition, not per stall cycle.
                        if (r_miss_count != CNT_MAX) begin
                            w_miss_count_next = r_miss_count + 1'b1;
                        end
                        w_word_cnt_next = '0;
                        w_state_next    = (w_valid && w_dirty) ? WRITEBACK : REFILL;
                    end
                end
            end

            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_victim_base | w_word_off;
                mem_wdata = w_victim_word;
                if (mem_ack) begin
                    if (r_word_cnt == LAST_WORD) begin
                        w_word_cnt_next = '0;
                        w_clean         = 1'b1;
                        w_state_next    = REFILL;
                    end else begin
                        w_word_cnt_next = r_word_cnt + 1'b1;
                    end
                end
            end

            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = w_fill_base | w_word_off;
                if (mem_ack) begin
                    w_fill_en = 1'b1;
                    if (r_word_cnt == LAST_WORD) begin
                        w_fill_done     = 1'b1;
                        w_word_cnt_next = '0;
                        w_state_next    = IDLE;
                    end else begin
                        w_word_cnt_next = r_word_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule
